// File: rtl/tile_mem_pkg.sv
// Shared definitions for the banked tile memory: NoC FSM states, command
// field positions and bank-interleaved address split helpers.
package tile_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_RESP = 2'd2
  } noc_state_e;

  localparam int CMD_WRITE_BIT = 63;

  // Low address bits select the bank so consecutive words spread across banks.
  function automatic logic [63:0] addr_bank(input logic [63:0] addr, input int bank_bits);
    return addr & ((64'd1 << bank_bits) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_word(input logic [63:0] addr, input int bank_bits);
    return addr >> bank_bits;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// Single-port SRAM bank: synchronous write, 1-cycle registered read,
// read-during-write returns the old word. No backpressure; contents are not reset.
module sram_bank #(
  parameter int WORDS      = 1024,
  parameter int DATA_WIDTH = 64,
  parameter int AW         = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/tile_memory_banked.sv
// Banked tile memory shared by per-bank PE ports and one NoC port; PE reads return in 1 cycle,
// NoC commands stall in ARB behind PE traffic until the bank is free or the starvation limit hits.
module tile_memory_banked
  import tile_mem_pkg::*;
#(
  parameter int BANKS        = 4,
  parameter int BANK_WORDS   = 1024,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BANKS-1:0]              bank_enable,
  input  logic [BANKS-1:0]              bank_write_en,
  input  logic [BANKS*$clog2(BANK_WORDS)-1:0] bank_addr,
  input  logic [BANKS*DATA_WIDTH-1:0]   bank_wdata,
  output logic [BANKS-1:0]              bank_ready,
  output logic [BANKS*DATA_WIDTH-1:0]   bank_rdata,
  output logic [BANKS-1:0]              bank_rvalid,
  input  logic                          noc_mem_valid,
  input  logic [63:0]                   noc_mem_cmd,
  input  logic [DATA_WIDTH-1:0]         noc_mem_wdata,
  output logic                          noc_mem_ready,
  output logic [DATA_WIDTH-1:0]         noc_mem_resp,
  output logic                          noc_mem_resp_valid,
  input  logic                          noc_mem_resp_ready
);

  localparam int AW  = $clog2(BANK_WORDS);
  localparam int BB  = $clog2(BANKS);
  localparam int GAW = AW + BB;
  localparam int WCW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  noc_state_e            state, state_nxt;
  logic [GAW-1:0]        cmd_addr_q;
  logic                  cmd_wr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] resp_q;
  logic [DATA_WIDTH-1:0] live_resp;
  logic [WCW-1:0]        wait_cnt;
  logic                  resp_live;
  logic                  grant;
  logic [BB-1:0]         tgt_bank;
  logic [AW-1:0]         tgt_word;
  logic [DATA_WIDTH-1:0] sram_rdata [BANKS];

  logic unused_cmd_bits;
  assign unused_cmd_bits = &{1'b0, noc_mem_cmd[CMD_WRITE_BIT-1:GAW]};

  assign tgt_bank = BB'(addr_bank(64'(cmd_addr_q), BB));
  assign tgt_word = AW'(addr_word(64'(cmd_addr_q), BB));

  assign grant = (state == ST_ARB) &&
                 (!bank_enable[tgt_bank] || (wait_cnt == WCW'(STARVE_LIMIT)));

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (noc_mem_valid)      state_nxt = ST_ARB;
      ST_ARB:  if (grant)              state_nxt = ST_RESP;
      ST_RESP: if (noc_mem_resp_ready) state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  assign noc_mem_ready      = (state == ST_IDLE);
  assign noc_mem_resp_valid = (state == ST_RESP);

  // The SRAM output is only valid in the first RESP cycle; later PE reads to the
  // same bank would disturb it, so the response is latched and replayed.
  assign live_resp    = cmd_wr_q ? '0 : sram_rdata[tgt_bank];
  assign noc_mem_resp = resp_live ? live_resp : resp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cmd_addr_q  <= '0;
      cmd_wr_q    <= 1'b0;
      wdata_q     <= '0;
      wait_cnt    <= '0;
      resp_live   <= 1'b0;
      resp_q      <= '0;
      bank_rvalid <= '0;
    end else begin
      state       <= state_nxt;
      resp_live   <= grant;
      bank_rvalid <= bank_enable & bank_ready & ~bank_write_en;
      if (state == ST_IDLE && noc_mem_valid) begin
        cmd_addr_q <= noc_mem_cmd[GAW-1:0];
        cmd_wr_q   <= noc_mem_cmd[CMD_WRITE_BIT];
        wdata_q    <= noc_mem_wdata;
      end
      if (grant) begin
        wait_cnt <= '0;
      end else if (state == ST_ARB && wait_cnt != WCW'(STARVE_LIMIT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (resp_live) resp_q <= live_resp;
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic noc_sel;
    assign noc_sel       = grant && (tgt_bank == BB'(b));
    assign bank_ready[b] = !noc_sel;

    sram_bank #(
      .WORDS      (BANK_WORDS),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_sram (
      .clk   (clk),
      .en    (noc_sel | bank_enable[b]),
      .we    (noc_sel ? cmd_wr_q : bank_write_en[b]),
      .addr  (noc_sel ? tgt_word : bank_addr[b*AW +: AW]),
      .wdata (noc_sel ? wdata_q  : bank_wdata[b*DATA_WIDTH +: DATA_WIDTH]),
      .rdata (sram_rdata[b])
    );

    assign bank_rdata[b*DATA_WIDTH +: DATA_WIDTH] = sram_rdata[b];
  end

endmodule

// File: tb/tb_tile_memory_banked.sv
// Self-checking bench for tile_memory_banked: directed cases plus randomized PE and
// NoC traffic checked against a global-address memory model.
module tb_tile_memory_banked;

  localparam int BANKS = 4;
  localparam int BANK_WORDS = 1024;
  localparam int DW = 64;
  localparam int SL = 8;
  localparam int AW = 10;
  localparam int GAW = 12;

  logic clk = 1'b0;
  logic rst;
  logic [BANKS-1:0]    bank_enable, bank_write_en, bank_ready, bank_rvalid;
  logic [BANKS*AW-1:0] bank_addr;
  logic [BANKS*DW-1:0] bank_wdata, bank_rdata;
  logic          noc_mem_valid, noc_mem_ready, noc_mem_resp_valid, noc_mem_resp_ready;
  logic [63:0]   noc_mem_cmd;
  logic [DW-1:0] noc_mem_wdata, noc_mem_resp;

  int errors = 0;
  int checks = 0;
  logic [63:0] model [int];

  always #5 clk = ~clk;

  tile_memory_banked #(.BANKS(BANKS), .BANK_WORDS(BANK_WORDS), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .bank_enable(bank_enable), .bank_write_en(bank_write_en), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_ready(bank_ready), .bank_rdata(bank_rdata),
    .bank_rvalid(bank_rvalid),
    .noc_mem_valid(noc_mem_valid), .noc_mem_cmd(noc_mem_cmd), .noc_mem_wdata(noc_mem_wdata),
    .noc_mem_ready(noc_mem_ready), .noc_mem_resp(noc_mem_resp),
    .noc_mem_resp_valid(noc_mem_resp_valid), .noc_mem_resp_ready(noc_mem_resp_ready)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int gaddr(input int bank, input int word);
    return word * BANKS + bank;
  endfunction

  task automatic sync;
    @(posedge clk); #1;
  endtask

  task automatic pe_idle;
    bank_enable = '0; bank_write_en = '0; bank_addr = '0; bank_wdata = '0;
  endtask

  task automatic pe_op(input int b, input logic we, input int word, input logic [63:0] d);
    bank_enable[b] = 1'b1;
    bank_write_en[b] = we;
    bank_addr[b*AW +: AW] = AW'(word);
    bank_wdata[b*DW +: DW] = d;
  endtask

  // Issues one NoC command and waits for its response; the expected grant cycle is
  // derived from the PE enables driven on the target bank during ARB.
  task automatic noc_issue(input logic wr, input int addr, input logic [63:0] wd, input logic rand_pe,
                           output int grant_cyc, output int exp_grant, output int resp_cyc,
                           output logic [63:0] resp);
    int tb_bank;
    tb_bank = addr % BANKS;
    sync();
    noc_mem_valid = 1'b1;
    noc_mem_cmd = '0;
    noc_mem_cmd[63] = wr;
    noc_mem_cmd[GAW-1:0] = GAW'(addr);
    noc_mem_wdata = wd;
    noc_mem_resp_ready = 1'b0;
    sync();
    noc_mem_valid = 1'b0;
    noc_mem_cmd = '0;
    grant_cyc = -1; exp_grant = -1; resp_cyc = -1; resp = '0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (rand_pe) begin
        bank_enable = BANKS'($urandom);
        bank_addr = BANKS*AW'($urandom);
      end
      if (exp_grant < 0 && (!bank_enable[tb_bank] || cyc == SL + 1)) exp_grant = cyc;
      @(negedge clk);
      if (grant_cyc < 0 && !bank_ready[tb_bank]) grant_cyc = cyc;
      if (noc_mem_resp_valid) begin
        resp_cyc = cyc;
        resp = noc_mem_resp;
        break;
      end
      sync();
    end
  endtask

  task automatic noc_consume;
    noc_mem_resp_ready = 1'b1;
    sync();
    noc_mem_resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pe_idle();
    noc_mem_valid = 1'b0; noc_mem_cmd = '0; noc_mem_wdata = '0; noc_mem_resp_ready = 1'b0;
    sync();
    @(negedge clk);
    checks++; if (bank_ready !== 4'hF) begin errors++; $display("FAIL reset_bank_ready: got %h want f", bank_ready); end
    checks++; if (bank_rvalid !== 4'h0) begin errors++; $display("FAIL reset_rvalid: got %h want 0", bank_rvalid); end
    checks++; if (noc_mem_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", noc_mem_resp_valid); end
    checks++; if (noc_mem_resp !== 64'h0) begin errors++; $display("FAIL reset_resp: got %h want 0", noc_mem_resp); end
    sync();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (noc_mem_ready !== 1'b1) begin errors++; $display("FAIL reset_noc_ready: got %b want 1", noc_mem_ready); end
  endtask

  task automatic test_pe_rw;
    sync();
    pe_op(2, 1'b1, 5, 64'h1111);
    @(negedge clk);
    checks++; if (bank_ready[2] !== 1'b1) begin errors++; $display("FAIL pe_ready: got %b want 1", bank_ready[2]); end
    sync();
    pe_op(2, 1'b1, 5, 64'hDEAD);
    @(negedge clk);
    checks++; if (bank_rvalid !== 4'h0) begin errors++; $display("FAIL pe_write_rvalid: got %h want 0", bank_rvalid); end
    sync();
    pe_op(2, 1'b0, 5, 64'h0);
    @(negedge clk);
    checks++; if (bank_rdata[2*DW +: DW] !== 64'h1111) begin errors++; $display("FAIL pe_rdw_old: got %h want 1111", bank_rdata[2*DW +: DW]); end
    sync();
    pe_idle();
    @(negedge clk);
    checks++; if (bank_rvalid !== 4'h4) begin errors++; $display("FAIL pe_rvalid: got %h want 4", bank_rvalid); end
    checks++; if (bank_rdata[2*DW +: DW] !== 64'hDEAD) begin errors++; $display("FAIL pe_rdata: got %h want dead", bank_rdata[2*DW +: DW]); end
    sync();
    @(negedge clk);
    checks++; if (bank_rvalid !== 4'h0) begin errors++; $display("FAIL pe_rvalid_drop: got %h want 0", bank_rvalid); end
    model[gaddr(2, 5)] = 64'hDEAD;
  endtask

  task automatic test_pe_random;
    logic pv [BANKS];
    logic pk [BANKS];
    logic [63:0] pd [BANKS];
    logic nv [BANKS];
    logic nk [BANKS];
    logic [63:0] nd [BANKS];
    for (int b = 0; b < BANKS; b++) begin pv[b] = 1'b0; pk[b] = 1'b0; pd[b] = '0; end
    sync();
    for (int cyc = 0; cyc <= 40; cyc++) begin
      pe_idle();
      for (int b = 0; b < BANKS; b++) begin
        int w;
        int g;
        logic en, we;
        logic [63:0] d;
        en = (cyc < 40) && ($urandom_range(0, 1) == 1);
        we = ($urandom_range(0, 1) == 1);
        w = $urandom_range(0, 7);
        d = {$urandom, $urandom};
        g = gaddr(b, w);
        nv[b] = 1'b0; nk[b] = 1'b0; nd[b] = '0;
        if (en) begin
          pe_op(b, we, w, d);
          if (!we) begin
            nv[b] = 1'b1;
            nk[b] = model.exists(g);
            if (nk[b]) nd[b] = model[g];
          end else begin
            model[g] = d;
          end
        end
      end
      @(negedge clk);
      checks++; if (bank_ready !== 4'hF) begin errors++; $display("FAIL rand_ready: got %h want f", bank_ready); end
      for (int b = 0; b < BANKS; b++) begin
        checks++; if (bank_rvalid[b] !== pv[b]) begin errors++; $display("FAIL rand_rvalid[%0d]: got %b want %b", b, bank_rvalid[b], pv[b]); end
        if (pv[b] && pk[b]) begin
          checks++; if (bank_rdata[b*DW +: DW] !== pd[b]) begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", b, bank_rdata[b*DW +: DW], pd[b]); end
        end
        pv[b] = nv[b]; pk[b] = nk[b]; pd[b] = nd[b];
      end
      sync();
    end
    pe_idle();
  endtask

  task automatic test_noc_write_read;
    int gc, eg, rc;
    logic [63:0] r;
    noc_issue(1'b1, 'h16, 64'h1234, 1'b0, gc, eg, rc, r);
    checks++; if (r !== 64'h0) begin errors++; $display("FAIL noc_write_resp: got %h want 0", r); end
    checks++; if (rc !== 2) begin errors++; $display("FAIL noc_write_resp_cycle: got %0d want 2", rc); end
    noc_consume();
    model['h16] = 64'h1234;
    noc_issue(1'b0, 'h16, 64'h0, 1'b0, gc, eg, rc, r);
    checks++; if (r !== 64'h1234) begin errors++; $display("FAIL noc_read_resp: got %h want 1234", r); end
    noc_consume();
    pe_op(2, 1'b0, 5, 64'h0);
    sync();
    pe_idle();
    @(negedge clk);
    checks++; if (bank_rvalid[2] !== 1'b1 || bank_rdata[2*DW +: DW] !== 64'h1234) begin
      errors++; $display("FAIL noc_interleave: got vld=%b data=%h want vld=1 data=1234", bank_rvalid[2], bank_rdata[2*DW +: DW]);
    end
  endtask

  task automatic test_noc_idle_bank;
    int gc, eg, rc;
    logic [63:0] r;
    noc_issue(1'b1, gaddr(1, 1), 64'hA5A5_0001, 1'b0, gc, eg, rc, r);
    noc_consume();
    noc_issue(1'b0, gaddr(1, 1), 64'h0, 1'b0, gc, eg, rc, r);
    checks++; if (gc !== 1) begin errors++; $display("FAIL idle_grant_cycle: got %0d want 1", gc); end
    checks++; if (rc !== 2) begin errors++; $display("FAIL idle_resp_cycle: got %0d want 2", rc); end
    checks++; if (r !== 64'hA5A5_0001) begin errors++; $display("FAIL idle_resp: got %h want a5a50001", r); end
    noc_consume();
    model[gaddr(1, 1)] = 64'hA5A5_0001;
  endtask

  task automatic test_starve;
    int gc, eg, rc;
    logic [63:0] r;
    noc_issue(1'b1, gaddr(0, 2), 64'h5EED_0002, 1'b0, gc, eg, rc, r);
    noc_consume();
    model[gaddr(0, 2)] = 64'h5EED_0002;
    pe_op(0, 1'b0, 2, 64'h0);
    for (int rep = 0; rep < 2; rep++) begin
      noc_issue(1'b0, gaddr(0, 2), 64'h0, 1'b0, gc, eg, rc, r);
      checks++; if (gc !== SL + 1) begin errors++; $display("FAIL starve_grant_cycle[%0d]: got %0d want %0d", rep, gc, SL + 1); end
      checks++; if (rc !== SL + 2) begin errors++; $display("FAIL starve_resp_cycle[%0d]: got %0d want %0d", rep, rc, SL + 2); end
      checks++; if (r !== 64'h5EED_0002) begin errors++; $display("FAIL starve_resp[%0d]: got %h want 5eed0002", rep, r); end
      checks++; if (bank_rvalid[0] !== 1'b0) begin errors++; $display("FAIL starve_pe_blocked[%0d]: got %b want 0", rep, bank_rvalid[0]); end
      noc_consume();
    end
    pe_idle();
  endtask

  task automatic test_resp_hold;
    int gc, eg, rc;
    logic [63:0] r;
    noc_issue(1'b1, gaddr(3, 4), 64'hC0DE_0004, 1'b0, gc, eg, rc, r);
    noc_consume();
    model[gaddr(3, 4)] = 64'hC0DE_0004;
    noc_issue(1'b0, gaddr(3, 4), 64'h0, 1'b0, gc, eg, rc, r);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        sync();
        pe_op(3, 1'b0, $urandom_range(100, 200), 64'h0);
        @(negedge clk);
      end
      checks++; if (noc_mem_resp_valid !== 1'b1 || noc_mem_resp !== 64'hC0DE_0004) begin
        errors++; $display("FAIL hold_resp[%0d]: got vld=%b data=%h want vld=1 data=c0de0004", i, noc_mem_resp_valid, noc_mem_resp);
      end
      checks++; if (noc_mem_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b want 0", i, noc_mem_ready); end
    end
    noc_mem_resp_ready = 1'b1;
    #1;
    checks++; if (noc_mem_ready !== 1'b0) begin errors++; $display("FAIL consume_ready: got %b want 0", noc_mem_ready); end
    sync();
    noc_mem_resp_ready = 1'b0;
    pe_idle();
    @(negedge clk);
    checks++; if (noc_mem_ready !== 1'b1 || noc_mem_resp_valid !== 1'b0) begin
      errors++; $display("FAIL after_consume: got rdy=%b vld=%b want rdy=1 vld=0", noc_mem_ready, noc_mem_resp_valid);
    end
  endtask

  task automatic test_reset_mid;
    int gc, eg, rc;
    logic [63:0] r;
    noc_issue(1'b1, gaddr(1, 7), 64'h01D0_0007, 1'b0, gc, eg, rc, r);
    noc_consume();
    model[gaddr(1, 7)] = 64'h01D0_0007;
    sync();
    pe_op(1, 1'b0, 7, 64'h0);
    noc_mem_valid = 1'b1;
    noc_mem_cmd = '0;
    noc_mem_cmd[63] = 1'b1;
    noc_mem_cmd[GAW-1:0] = GAW'(gaddr(1, 7));
    noc_mem_wdata = 64'hBAD0_BAD0;
    sync();
    noc_mem_valid = 1'b0;
    sync();
    @(negedge clk);
    checks++; if (noc_mem_ready !== 1'b0) begin errors++; $display("FAIL mid_arb_ready: got %b want 0", noc_mem_ready); end
    rst = 1'b1;
    #1;
    checks++; if (noc_mem_ready !== 1'b1 || bank_ready !== 4'hF || bank_rvalid !== 4'h0 ||
                  noc_mem_resp_valid !== 1'b0 || noc_mem_resp !== 64'h0) begin
      errors++; $display("FAIL mid_reset_outputs: got rdy=%b brdy=%h rv=%h vld=%b resp=%h want 1 f 0 0 0",
                         noc_mem_ready, bank_ready, bank_rvalid, noc_mem_resp_valid, noc_mem_resp);
    end
    sync();
    pe_idle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (noc_mem_ready !== 1'b1 || bank_ready !== 4'hF) begin
        errors++; $display("FAIL post_reset_idle[%0d]: got rdy=%b brdy=%h want 1 f", i, noc_mem_ready, bank_ready);
      end
    end
    noc_issue(1'b0, gaddr(1, 7), 64'h0, 1'b0, gc, eg, rc, r);
    checks++; if (r !== 64'h01D0_0007) begin errors++; $display("FAIL dropped_write: got %h want 01d00007", r); end
    noc_consume();
  endtask

  task automatic test_back_to_back;
    int gc, eg, rc, addr;
    logic wr;
    logic [63:0] r, d, exp_r;
    for (int t = 0; t < 12; t++) begin
      addr = $urandom_range(0, 31);
      wr = ($urandom_range(0, 1) == 1) || !model.exists(addr);
      d = {$urandom, $urandom};
      exp_r = wr ? 64'h0 : model[addr];
      noc_issue(wr, addr, d, 1'b1, gc, eg, rc, r);
      if (wr) model[addr] = d;
      checks++; if (gc !== eg) begin errors++; $display("FAIL b2b_grant[%0d]: got %0d want %0d", t, gc, eg); end
      checks++; if (rc !== eg + 1) begin errors++; $display("FAIL b2b_resp_cycle[%0d]: got %0d want %0d", t, rc, eg + 1); end
      checks++; if (r !== exp_r) begin errors++; $display("FAIL b2b_resp[%0d]: got %h want %h", t, r, exp_r); end
      noc_consume();
    end
    pe_idle();
  endtask

  initial begin
    test_reset();
    test_pe_rw();
    test_pe_random();
    test_noc_write_read();
    test_noc_idle_bank();
    test_starve();
    test_resp_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
